// File: rtl/rgb_to_gray_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rgb_to_gray_arbiter
// Brief    : Two-requester burst arbiter that feeds RGB pixels to a shared
//            gray-conversion datapath and sequences its stage enables.
//            PIXEL_BURST legal range is 1..15.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rgb_to_gray_arbiter #(
  parameter int PIXEL_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [23:0] req0_rgb,
  input  logic [23:0] req1_rgb,
  output logic [7:0]  dp_R,
  output logic [7:0]  dp_G,
  output logic [7:0]  dp_B,
  output logic        dp_load_reg_en,
  output logic        dp_turn_reg_en,
  output logic        dp_none_scale_result_reg_en,
  output logic        dp_scale_result_reg_en,
  input  logic [31:0] dp_gray,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_gray,
  output logic        out_id,
  output logic [15:0] px_cnt0,
  output logic [15:0] px_cnt1,
  output logic        busy
);

  localparam logic [3:0] c_burst = 4'(PIXEL_BURST);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_TURN   = 3'd2,
    S_NSCALE = 3'd3,
    S_SCALE  = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_prio;
  logic [3:0]  r_cnt;
  logic [7:0]  r_R;
  logic [7:0]  r_G;
  logic [7:0]  r_B;
  logic        r_id;
  logic        r_load_en;
  logic        r_turn_en;
  logic        r_nscale_en;
  logic        r_scale_en;
  logic        r_out_valid;
  logic [15:0] r_px_cnt0;
  logic [15:0] r_px_cnt1;

  logic        w_any;
  logic        w_grant;
  logic        w_accept;
  logic [3:0]  w_cnt_inc;
  logic        w_burst_hit;
  logic [23:0] w_rgb;

  assign w_any    = req0_valid | req1_valid;
  assign w_grant  = (req0_valid & req1_valid) ? r_prio : req1_valid;
  // Ready is gated by rst so both readys read 0 while reset is held.
  assign w_accept = rst & (r_state == S_IDLE) & w_any;
  assign w_rgb    = w_grant ? req1_rgb : req0_rgb;

  // A grant to the non-priority side restarts its burst at 1; either way the
  // granted requester becomes priority until its burst is exhausted.
  assign w_cnt_inc   = (w_grant == r_prio) ? (r_cnt + 4'd1) : 4'd1;
  assign w_burst_hit = (w_cnt_inc == c_burst);

  assign req0_ready = w_accept & ~w_grant;
  assign req1_ready = w_accept &  w_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_prio      <= 1'b0;
      r_cnt       <= 4'd0;
      r_R         <= 8'd0;
      r_G         <= 8'd0;
      r_B         <= 8'd0;
      r_id        <= 1'b0;
      r_load_en   <= 1'b0;
      r_turn_en   <= 1'b0;
      r_nscale_en <= 1'b0;
      r_scale_en  <= 1'b0;
      r_out_valid <= 1'b0;
      r_px_cnt0   <= 16'd0;
      r_px_cnt1   <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_R       <= w_rgb[23:16];
            r_G       <= w_rgb[15:8];
            r_B       <= w_rgb[7:0];
            r_id      <= w_grant;
            r_prio    <= w_burst_hit ? ~w_grant : w_grant;
            r_cnt     <= w_burst_hit ? 4'd0 : w_cnt_inc;
            r_load_en <= 1'b1;
            r_state   <= S_LOAD;
            if (w_grant) r_px_cnt1 <= r_px_cnt1 + 16'd1;
            else         r_px_cnt0 <= r_px_cnt0 + 16'd1;
          end
        end
        S_LOAD: begin
          r_load_en <= 1'b0;
          r_turn_en <= 1'b1;
          r_state   <= S_TURN;
        end
        S_TURN: begin
          r_turn_en   <= 1'b0;
          r_nscale_en <= 1'b1;
          r_state     <= S_NSCALE;
        end
        S_NSCALE: begin
          r_nscale_en <= 1'b0;
          r_scale_en  <= 1'b1;
          r_state     <= S_SCALE;
        end
        S_SCALE: begin
          r_scale_en  <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_load_en   <= 1'b0;
          r_turn_en   <= 1'b0;
          r_nscale_en <= 1'b0;
          r_scale_en  <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign dp_R                        = r_R;
  assign dp_G                        = r_G;
  assign dp_B                        = r_B;
  assign dp_load_reg_en              = r_load_en;
  assign dp_turn_reg_en              = r_turn_en;
  assign dp_none_scale_result_reg_en = r_nscale_en;
  assign dp_scale_result_reg_en      = r_scale_en;
  assign out_valid                   = r_out_valid;
  assign out_gray                    = dp_gray;
  assign out_id                      = r_id;
  assign px_cnt0                     = r_px_cnt0;
  assign px_cnt1                     = r_px_cnt1;
  assign busy                        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rgb_to_gray_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_rgb_to_gray_arbiter
// Brief    : Bench for rgb_to_gray_arbiter; two instances (burst 4 and 1)
//            share stimulus and are checked against a cycle model scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rgb_to_gray_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] gray;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, out_ready = 1'b1;
  logic [23:0] rgb0 = 24'd0, rgb1 = 24'd0;

  logic [1:0]  rdy0, rdy1, en_ld, en_tr, en_ns, en_sc, ovld, oid, bsy;
  logic [7:0]  dpR [2];
  logic [7:0]  dpG [2];
  logic [7:0]  dpB [2];
  logic [31:0] dpg [2];
  logic [31:0] ogray [2];
  logic [15:0] pxc0 [2];
  logic [15:0] pxc1 [2];

  int checks = 0, passes = 0, fails = 0;

  always #5 clk = ~clk;

  // Stand-in datapath: result tag plus the presented channel bytes.
  assign dpg[0] = {8'hA5, dpR[0], dpG[0], dpB[0]};
  assign dpg[1] = {8'hA5, dpR[1], dpG[1], dpB[1]};

  rgb_to_gray_arbiter #(.PIXEL_BURST(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req1_valid(v1),
    .req0_ready(rdy0[0]), .req1_ready(rdy1[0]),
    .req0_rgb(rgb0), .req1_rgb(rgb1),
    .dp_R(dpR[0]), .dp_G(dpG[0]), .dp_B(dpB[0]),
    .dp_load_reg_en(en_ld[0]), .dp_turn_reg_en(en_tr[0]),
    .dp_none_scale_result_reg_en(en_ns[0]), .dp_scale_result_reg_en(en_sc[0]),
    .dp_gray(dpg[0]),
    .out_valid(ovld[0]), .out_ready(out_ready), .out_gray(ogray[0]), .out_id(oid[0]),
    .px_cnt0(pxc0[0]), .px_cnt1(pxc1[0]), .busy(bsy[0])
  );

  rgb_to_gray_arbiter #(.PIXEL_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req1_valid(v1),
    .req0_ready(rdy0[1]), .req1_ready(rdy1[1]),
    .req0_rgb(rgb0), .req1_rgb(rgb1),
    .dp_R(dpR[1]), .dp_G(dpG[1]), .dp_B(dpB[1]),
    .dp_load_reg_en(en_ld[1]), .dp_turn_reg_en(en_tr[1]),
    .dp_none_scale_result_reg_en(en_ns[1]), .dp_scale_result_reg_en(en_sc[1]),
    .dp_gray(dpg[1]),
    .out_valid(ovld[1]), .out_ready(out_ready), .out_gray(ogray[1]), .out_id(oid[1]),
    .px_cnt0(pxc0[1]), .px_cnt1(pxc1[1]), .busy(bsy[1])
  );

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Reference model state, one slot per instance.
  int          ph [2];
  int          bst [2] = '{4, 1};
  logic        prio [2];
  logic [3:0]  cnt [2];
  logic [15:0] pc0 [2];
  logic [15:0] pc1 [2];
  logic [23:0] m_rgb [2];
  logic        m_id [2];
  exp_t        qa [$];
  exp_t        qb [$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        ph[k] = 0; prio[k] = 1'b0; cnt[k] = 4'd0;
        pc0[k] = 16'd0; pc1[k] = 16'd0; m_rgb[k] = 24'd0; m_id[k] = 1'b0;
      end
      qa.delete();
      qb.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic  g;
        exp_t  e;
        case (ph[k])
          0: if (v0 || v1) begin
            g = (v0 && v1) ? prio[k] : v1;
            m_rgb[k] = g ? rgb1 : rgb0;
            m_id[k]  = g;
            e.id   = g;
            e.gray = {8'hA5, m_rgb[k]};
            if (k == 0) qa.push_back(e); else qb.push_back(e);
            if (g) pc1[k] = pc1[k] + 16'd1; else pc0[k] = pc0[k] + 16'd1;
            if (g == prio[k]) cnt[k] = cnt[k] + 4'd1;
            else begin prio[k] = g; cnt[k] = 4'd1; end
            if (int'(cnt[k]) == bst[k]) begin prio[k] = ~prio[k]; cnt[k] = 4'd0; end
            ph[k] = 1;
          end
          1, 2, 3, 4: ph[k] = ph[k] + 1;
          default: if (out_ready) begin
            if (k == 0 && qa.size() > 0) void'(qa.pop_front());
            if (k == 1 && qb.size() > 0) void'(qb.pop_front());
            ph[k] = 0;
          end
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model, away from the edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic e0, e1;
      int   qs;
      exp_t f;
      e0 = rst && ph[k] == 0 && v0 && (!v1 || !prio[k]);
      e1 = rst && ph[k] == 0 && v1 && (!v0 ||  prio[k]);
      chk("req0_ready", k, 32'(rdy0[k]), 32'(e0));
      chk("req1_ready", k, 32'(rdy1[k]), 32'(e1));
      chk("busy", k, 32'(bsy[k]), 32'(ph[k] != 0));
      chk("load_en", k, 32'(en_ld[k]), 32'(ph[k] == 1));
      chk("turn_en", k, 32'(en_tr[k]), 32'(ph[k] == 2));
      chk("nscale_en", k, 32'(en_ns[k]), 32'(ph[k] == 3));
      chk("scale_en", k, 32'(en_sc[k]), 32'(ph[k] == 4));
      chk("out_valid", k, 32'(ovld[k]), 32'(ph[k] == 5));
      chk("dp_rgb", k, {8'h0, dpR[k], dpG[k], dpB[k]}, {8'h0, m_rgb[k]});
      chk("out_gray_pass", k, ogray[k], dpg[k]);
      chk("out_id", k, 32'(oid[k]), 32'(m_id[k]));
      chk("px_cnt0", k, 32'(pxc0[k]), 32'(pc0[k]));
      chk("px_cnt1", k, 32'(pxc1[k]), 32'(pc1[k]));
      if (ph[k] == 5) begin
        qs = (k == 0) ? qa.size() : qb.size();
        chk("sb_has_entry", k, 32'(qs != 0), 32'd1);
        if (qs != 0) begin
          f = (k == 0) ? qa[0] : qb[0];
          chk("sb_out_id", k, 32'(oid[k]), 32'(f.id));
          chk("sb_out_gray", k, ogray[k], f.gray);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tick(3);
    rst = 1'b1;

    // Single pixel on requester 0.
    tick(1);
    v0 = 1'b1; rgb0 = 24'h102030;
    tick(1);
    v0 = 1'b0;
    chk("single_dp_R", 0, 32'(dpR[0]), 32'h10);
    chk("single_dp_G", 0, 32'(dpG[0]), 32'h20);
    chk("single_dp_B", 0, 32'(dpB[0]), 32'h30);
    tick(6);
    chk("single_px_cnt0", 0, 32'(pxc0[0]), 32'd1);

    // Fresh arbitration state, then sustained contention for 8 pixels.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    v0 = 1'b1; v1 = 1'b1; rgb0 = 24'h0A0B0C; rgb1 = 24'hC0B0A0;
    tick(44);
    v0 = 1'b0; v1 = 1'b0;
    tick(6);
    for (int k = 0; k < 2; k++) begin
      chk("cont_px_cnt0", k, 32'(pxc0[k]), 32'd4);
      chk("cont_px_cnt1", k, 32'(pxc1[k]), 32'd4);
    end

    // Only requester 1 valid: it wins every pixel.
    v1 = 1'b1; rgb1 = 24'h55AA33;
    tick(13);
    v1 = 1'b0;
    tick(6);
    for (int k = 0; k < 2; k++) chk("solo_px_cnt1", k, 32'(pxc1[k]), 32'd7);

    // Backpressure, with requester 1 raising valid while the block is busy.
    out_ready = 1'b0;
    v0 = 1'b1; rgb0 = 24'h405060;
    tick(1);
    v0 = 1'b0;
    tick(3);
    v1 = 1'b1; rgb1 = 24'hFFEEDD;
    tick(12);
    chk("bp_out_valid", 0, 32'(ovld[0]), 32'd1);
    out_ready = 1'b1;
    tick(2);
    v1 = 1'b0;
    chk("bp_dp_R_next", 1, 32'(dpR[1]), 32'hFF);
    tick(6);

    // Reset asserted while the pixel sits in TURN.
    v0 = 1'b1; rgb0 = 24'h778899;
    tick(1);
    v0 = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_turn_en", k, 32'(en_tr[k]), 32'd0);
      chk("rst_busy", k, 32'(bsy[k]), 32'd0);
      chk("rst_px_cnt0", k, 32'(pxc0[k]), 32'd0);
    end
    tick(2);
    rst = 1'b1;
    v1 = 1'b1; rgb1 = 24'h123456;
    tick(1);
    v1 = 1'b0;
    tick(7);

    // Requester-1 counter wrap on the burst-4 instance.
    force u_dut0.r_px_cnt1 = 16'hFFFF;
    pc1[0] = 16'hFFFF;
    tick(1);
    release u_dut0.r_px_cnt1;
    tick(1);
    v1 = 1'b1; rgb1 = 24'h0F0F0F;
    tick(1);
    v1 = 1'b0;
    chk("wrap_px_cnt1", 0, 32'(pxc1[0]), 32'h0000);
    chk("wrap_px_cnt0", 0, 32'(pxc0[0]), 32'h0000);
    tick(7);

    chk("sb_drained", 0, 32'(qa.size()), 32'd0);
    chk("sb_drained", 1, 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
